// File: rtl/sm_access_monitor.sv
`default_nettype none
// ============================================================================
// Module : sm_access_monitor
// Brief  : Multi-slot protected-module access monitor with violation reset.
// Rev    : 1.0
// ============================================================================
module sm_access_monitor #(
  parameter int NUM_SM    = 4,
  parameter int ADDR_W    = 16,
  parameter int RST_PULSE = 8,
  parameter int CNT_W     = 8,
  parameter int IDX_W     = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
) (
  input  logic              mclk,
  input  logic              puc_rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] prev_pc,
  input  logic              data_en,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              cfg_wr,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [2:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              cfg_lock,
  output logic              cfg_err,
  output logic              reset,
  output logic [2:0]        viol_cause,
  output logic [IDX_W-1:0]  viol_sm,
  output logic [CNT_W-1:0]  viol_cnt
);

  localparam int C_PCNT_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [C_PCNT_W-1:0] C_PCNT_LOAD = C_PCNT_W'(RST_PULSE - 1);

  localparam logic [2:0] C_F_TEXT_START = 3'd0;
  localparam logic [2:0] C_F_TEXT_STOP  = 3'd1;
  localparam logic [2:0] C_F_DATA_START = 3'd2;
  localparam logic [2:0] C_F_DATA_STOP  = 3'd3;
  localparam logic [2:0] C_F_ENABLE     = 3'd4;

  typedef enum logic [0:0] {
    ST_MON   = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  logic [ADDR_W-1:0] r_text_start [NUM_SM];
  logic [ADDR_W-1:0] r_text_stop  [NUM_SM];
  logic [ADDR_W-1:0] r_data_start [NUM_SM];
  logic [ADDR_W-1:0] r_data_stop  [NUM_SM];
  logic [NUM_SM-1:0] r_en;
  logic              r_lock;
  logic              r_cfg_err;

  state_t             r_state;
  logic [C_PCNT_W-1:0] r_pcnt;
  logic               r_reset;
  logic [2:0]         r_viol_cause;
  logic [IDX_W-1:0]   r_viol_sm;
  logic [CNT_W-1:0]   r_viol_cnt;

  logic [NUM_SM-1:0] w_entry;
  logic [NUM_SM-1:0] w_data;
  logic [NUM_SM-1:0] w_textw;
  logic [NUM_SM-1:0] w_hit;
  logic [2:0]        w_cause;
  logic              w_viol;
  logic [IDX_W-1:0]  w_viol_sm;
  logic              w_idx_ok;
  logic              w_tgt_en;
  logic              w_cfg_ok;
  logic              w_cfg_acc;

  // Per-slot range decode; a range with start >= stop can never match.
  generate
    for (genvar gi = 0; gi < NUM_SM; gi++) begin : g_slot
      logic w_pc_in_text;
      logic w_prev_in_text;
      logic w_daddr_in_text;
      logic w_daddr_in_data;

      assign w_pc_in_text    = (pc >= r_text_start[gi]) && (pc < r_text_stop[gi]);
      assign w_prev_in_text  = (prev_pc >= r_text_start[gi]) && (prev_pc < r_text_stop[gi]);
      assign w_daddr_in_text = (data_addr >= r_text_start[gi]) && (data_addr < r_text_stop[gi]);
      assign w_daddr_in_data = (data_addr >= r_data_start[gi]) && (data_addr < r_data_stop[gi]);

      assign w_entry[gi] = r_en[gi] && w_pc_in_text && !w_prev_in_text && (pc != r_text_start[gi]);
      assign w_data[gi]  = r_en[gi] && data_en && w_daddr_in_data && !w_pc_in_text;
      assign w_textw[gi] = r_en[gi] && data_en && data_wr && w_daddr_in_text;
    end
  endgenerate

  assign w_hit   = w_entry | w_data | w_textw;
  assign w_cause = {|w_textw, |w_data, |w_entry};
  assign w_viol  = |w_hit;

  always_comb begin
    w_viol_sm = '0;
    for (int i = NUM_SM - 1; i >= 0; i--) begin
      if (w_hit[i]) w_viol_sm = IDX_W'(i);
    end
  end

  // Slot lookup by comparison so an out-of-range cfg_idx never indexes the arrays.
  always_comb begin
    w_idx_ok = 1'b0;
    w_tgt_en = 1'b0;
    for (int i = 0; i < NUM_SM; i++) begin
      if (cfg_idx == IDX_W'(i)) begin
        w_idx_ok = 1'b1;
        w_tgt_en = r_en[i];
      end
    end
  end

  assign w_cfg_ok  = !r_lock && w_idx_ok && (cfg_field <= C_F_ENABLE) &&
                     (!w_tgt_en || (cfg_field == C_F_ENABLE));
  assign w_cfg_acc = cfg_wr && w_cfg_ok;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      for (int i = 0; i < NUM_SM; i++) begin
        r_text_start[i] <= '0;
        r_text_stop[i]  <= '0;
        r_data_start[i] <= '0;
        r_data_stop[i]  <= '0;
      end
      r_en      <= '0;
      r_lock    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_lock    <= r_lock | cfg_lock;
      r_cfg_err <= cfg_wr && !w_cfg_ok;
      if (w_cfg_acc) begin
        for (int i = 0; i < NUM_SM; i++) begin
          if (cfg_idx == IDX_W'(i)) begin
            case (cfg_field)
              C_F_TEXT_START: r_text_start[i] <= cfg_data;
              C_F_TEXT_STOP:  r_text_stop[i]  <= cfg_data;
              C_F_DATA_START: r_data_start[i] <= cfg_data;
              C_F_DATA_STOP:  r_data_stop[i]  <= cfg_data;
              C_F_ENABLE:     r_en[i]         <= cfg_data[0];
              default:        ;
            endcase
          end
        end
      end
    end
  end

  // Violations seen while the pulse is running are deliberately dropped.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_state      <= ST_MON;
      r_pcnt       <= '0;
      r_reset      <= 1'b0;
      r_viol_cause <= '0;
      r_viol_sm    <= '0;
      r_viol_cnt   <= '0;
    end else begin
      case (r_state)
        ST_MON: begin
          if (w_viol) begin
            r_viol_cause <= w_cause;
            r_viol_sm    <= w_viol_sm;
            if (r_viol_cnt != {CNT_W{1'b1}}) r_viol_cnt <= r_viol_cnt + 1'b1;
            r_pcnt       <= C_PCNT_LOAD;
            r_reset      <= 1'b1;
            r_state      <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (r_pcnt == '0) begin
            r_reset <= 1'b0;
            r_state <= ST_MON;
          end else begin
            r_pcnt <= r_pcnt - 1'b1;
          end
        end
        default: r_state <= ST_MON;
      endcase
    end
  end

  assign cfg_err    = r_cfg_err;
  assign reset      = r_reset;
  assign viol_cause = r_viol_cause;
  assign viol_sm    = r_viol_sm;
  assign viol_cnt   = r_viol_cnt;

endmodule
`default_nettype wire

// File: doc/sm_access_monitor.md
# sm_access_monitor

Multi-module memory access monitor for the Sancus-style openMSP430 evaluation harness. It tracks up to NUM_SM protected modules, each with its own text and data section. Each cycle it checks the fetched PC, the previous PC and the data bus against every enabled module. On a violation it drives a registered, fixed-length reset pulse and records the cause, the offending module and a saturating violation count. Module sections are loaded at runtime through a small configuration port with a lock bit, replacing the earlier hard-wired single-module check.

## Interface

Parameters
- NUM_SM, 4: number of protected-module slots (1..16).
- ADDR_W, 16: address width of pc, prev_pc, data_addr and the section bounds.
- RST_PULSE, 8: reset pulse length in cycles (must be ≥1).
- CNT_W, 8: width of the violation counter.
- IDX_W, $clog2(NUM_SM) (minimum 1): slot index width.

Ports
- mclk  in  1  system clock; all state is updated on its rising edge.
- puc_rst_n  in  1  asynchronous active-low reset; clears all state, including the slot configuration.
- pc  in  ADDR_W  address of the current instruction.
- prev_pc  in  ADDR_W  address of the previous instruction.
- data_en  in  1  data bus access valid.
- data_wr  in  1  data access is a write (qualified by data_en).
- data_addr  in  ADDR_W  data bus address.
- cfg_wr  in  1  configuration write strobe.
- cfg_idx  in  IDX_W  target slot.
- cfg_field  in  3  selects the field: 0 text_start, 1 text_stop, 2 data_start, 3 data_stop, 4 enable (cfg_data[0]); 5..7 are reserved.
- cfg_data  in  ADDR_W  write data.
- cfg_lock  in  1  sticky lock; once sampled high, every later cfg_wr is rejected until puc_rst_n.
- cfg_err  out  1  one-cycle pulse when a cfg_wr was rejected.
- reset  out  1  registered violation reset pulse.
- viol_cause  out  3  cause of the last latched violation: bit0 illegal entry, bit1 illegal data access, bit2 write to a text section.
- viol_sm  out  IDX_W  lowest slot index involved in the last latched violation.
- viol_cnt  out  CNT_W  number of latched violations; saturates at all-ones.

## Operation

Range and slot rules
- Ranges are half-open: [start, stop). A range with start ≥ stop is empty and never matches.
- Only slots with enable=1 participate in checks.

Violation rules (evaluated combinationally each cycle, against the configuration before any same-cycle write):
- Entry violation: pc is in text(i) and prev_pc is not in text(i), but pc ≠ text_start(i).
- Data violation: data_en=1 and data_addr is in data(i), but pc is not in text(i).
- Text-write violation: data_en=1, data_wr=1 and data_addr is in text(i).
- If several rules fire in the same cycle, viol_cause records all of them (bitwise OR). viol_sm records the lowest index over all firing rules.

State machine
- States: MON and PULSE.
- MON: on any violation, latch viol_cause and viol_sm, increment viol_cnt (saturating), load the pulse counter with RST_PULSE−1, assert reset, and go to PULSE.
- PULSE: reset stays high. The counter decrements each cycle; on reaching 0, reset deasserts and the FSM returns to MON.
- Violations during PULSE are ignored: nothing is latched and nothing is counted.

Configuration
- A write is rejected, with cfg_err pulsed and no state change, when any of these holds:
  - lock is set;
  - cfg_idx ≥ NUM_SM;
  - cfg_field is reserved;
  - the target slot is enabled and cfg_field ≠ 4.
- A slot can therefore always be disabled, but its bounds cannot change while it is enabled.
- Configuration writes are accepted in both MON and PULSE.
- Violation reset does not clear the slot configuration, the lock, viol_cause, viol_sm or viol_cnt. Only puc_rst_n clears them.

## Timing

- Reset values: reset=0, cfg_err=0, viol_cause=0, viol_sm=0, viol_cnt=0. All slot fields are 0 and disabled, lock=0, FSM in MON.
- Violation latency: a violating input in cycle N produces reset=1 from cycle N+1 for exactly RST_PULSE cycles. viol_cause, viol_sm and viol_cnt update at the same edge.
- Back-to-back violations: the first cycle in which a new violation can be latched is the first MON cycle after the pulse ends.
- Configuration: a write accepted in cycle N is visible to the checks in cycle N+1. cfg_err is high in cycle N+1 only.
- cfg_lock takes effect at the edge where it is sampled. A cfg_wr in that same cycle is still accepted.
- puc_rst_n assertion in the middle of a pulse clears reset immediately (asynchronously).
- viol_cnt holds at 2^CNT_W−1 and never wraps.

## Test plan

- Entry check: configure slot 0 with text A000..A400 and data 0500..0C00, then enable it. Apply pc=A010, prev_pc=8000 → reset high for 8 cycles starting the next cycle; viol_cause=001, viol_sm=0, viol_cnt=1. Apply pc=A000, prev_pc=8000 → no violation.
- Data check: with the slot 0 config above, apply pc=8000, data_en=1, data_addr=0600 → viol_cause=010. Apply pc=A100, same access → no violation. Apply data_addr=0C00 from outside → no violation (stop bound is exclusive).
- Multiple rules and slots: enable slot 0 as above and slot 1 with text A000..B000. Apply a write to A200 from pc=8000 → viol_cause=100, viol_sm=0. A second violation during the pulse → viol_cnt unchanged.
- Configuration errors: write field 0 to enabled slot 0 → cfg_err pulse, bounds unchanged. Write field 4 with cfg_data=0 → accepted, slot disabled. Assert cfg_lock, then write → cfg_err. Write cfg_field=6 → cfg_err.
- Saturation with CNT_W=2: trigger 5 separated violations → viol_cnt ends at 3.
- Reset mid-pulse: assert puc_rst_n=0 in pulse cycle 3 → reset=0 immediately; all outputs and configuration at their reset values; after release, an access to 0600 from pc=8000 does not violate (no slot enabled).
